// File: rtl/lc_tx_filter.sv
// Debounces and validates a synchronized lc_tx_t enable; On needs FilterCycles consecutive On samples,
// any non-On sample drops to Off in one edge, and too many consecutive invalid codes latch a fatal error.
module lc_tx_filter #(
  parameter int FilterCycles = 2,
  parameter int MaxTransient = 1,
  parameter int CntWidth     = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [3:0]          lc_en_i,
  output logic [3:0]          lc_en_o,
  output logic                en_o,
  output logic                on_pulse_o,
  output logic                err_o,
  output logic [CntWidth-1:0] transient_cnt_o
);

  localparam int FW = (FilterCycles < 1) ? 1 : $clog2(FilterCycles + 1);
  localparam int TW = $clog2(MaxTransient + 2);

  localparam logic [3:0] LcOn  = 4'hA;
  localparam logic [3:0] LcOff = 4'h5;

  // Sparse encodings: a single upset cannot turn one legal state into another.
  typedef enum logic [5:0] {
    OffSt = 6'b010110,
    ArmSt = 6'b101001,
    OnSt  = 6'b110011,
    ErrSt = 6'b001100
  } state_e;

  state_e                state_q, state_d;
  logic [FW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         trun_q, trun_d;
  logic [CntWidth-1:0]   tcnt_q, tcnt_d;
  logic [3:0]            lc_en_q, lc_en_d;
  logic                  en_q, en_d;
  logic                  on_pulse_q, on_pulse_d;
  logic                  err_q, err_d;

  logic is_on, is_inv, live;

  always_comb begin
    is_on   = (lc_en_i == LcOn);
    is_inv  = (lc_en_i != LcOn) && (lc_en_i != LcOff);
    live    = (state_q == OffSt) || (state_q == ArmSt) || (state_q == OnSt);
    state_d = state_q;
    cnt_d   = cnt_q;
    trun_d  = trun_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      OffSt: begin
        if (is_on) begin
          cnt_d   = FW'(1);
          state_d = (FilterCycles <= 1) ? OnSt : ArmSt;
        end else begin
          cnt_d = '0;
        end
      end
      ArmSt: begin
        if (is_on) begin
          cnt_d = cnt_q + FW'(1);
          if (int'(cnt_q) + 1 >= FilterCycles) state_d = OnSt;
        end else begin
          cnt_d   = '0;
          state_d = OffSt;
        end
      end
      OnSt: begin
        if (!is_on) begin
          cnt_d   = '0;
          state_d = OffSt;
        end
      end
      default: state_d = ErrSt;
    endcase

    // The transient run is tracked in every live state; exceeding it wins over any other move.
    if (live) begin
      if (is_inv) begin
        if (tcnt_q != {CntWidth{1'b1}}) tcnt_d = tcnt_q + CntWidth'(1);
        if (int'(trun_q) + 1 > MaxTransient) begin
          state_d = ErrSt;
        end else begin
          trun_d = trun_q + TW'(1);
        end
      end else begin
        trun_d = '0;
      end
    end

    lc_en_d    = (state_d == OnSt) ? LcOn : LcOff;
    en_d       = (state_d == OnSt);
    on_pulse_d = (state_d == OnSt) && (state_q != OnSt);
    err_d      = (state_d == ErrSt);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= OffSt;
      cnt_q      <= '0;
      trun_q     <= '0;
      tcnt_q     <= '0;
      lc_en_q    <= LcOff;
      en_q       <= 1'b0;
      on_pulse_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trun_q     <= trun_d;
      tcnt_q     <= tcnt_d;
      lc_en_q    <= lc_en_d;
      en_q       <= en_d;
      on_pulse_q <= on_pulse_d;
      err_q      <= err_d;
    end
  end

  assign lc_en_o         = lc_en_q;
  assign en_o            = en_q;
  assign on_pulse_o      = on_pulse_q;
  assign err_o           = err_q;
  assign transient_cnt_o = tcnt_q;

  a_lc_en_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lc_en_o == LcOn) || (lc_en_o == LcOff));
  a_err_sticky: assert property (@(posedge clk_i) (err_o && rst_ni) |=> err_o);
  a_en_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    en_o == (lc_en_o == LcOn));

endmodule

// File: tb/tb_lc_tx_filter.sv
// Directed bench: stimulus pushes hand-computed expected outputs, a monitor pops and compares each cycle.
module tb_lc_tx_filter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] lc_en_i = 4'h5;
  logic [3:0] lc_en_o;
  logic       en_o;
  logic       on_pulse_o;
  logic       err_o;
  logic [1:0] transient_cnt_o;

  typedef struct packed {
    logic [3:0] lc_en;
    logic       en;
    logic       pulse;
    logic       err;
    logic [1:0] cnt;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  lc_tx_filter #(.FilterCycles(2), .MaxTransient(1), .CntWidth(2)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .lc_en_i         (lc_en_i),
    .lc_en_o         (lc_en_o),
    .en_o            (en_o),
    .on_pulse_o      (on_pulse_o),
    .err_o           (err_o),
    .transient_cnt_o (transient_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one sample before the next edge and record what the outputs must be after it.
  task automatic step(input string name, input logic rst, input logic [3:0] din,
                      input logic on, input logic pulse, input logic err, input logic [1:0] cnt);
    exp_t e;
    @(negedge clk_i);
    rst_ni  = rst;
    lc_en_i = din;
    e.name = name;
    e.exp  = '{lc_en: (on ? 4'hA : 4'h5), en: on, pulse: pulse, err: err, cnt: cnt};
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    obs_t act;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = '{lc_en: lc_en_o, en: en_o, pulse: on_pulse_o, err: err_o, cnt: transient_cnt_o};
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got lc_en=%h en=%b pulse=%b err=%b cnt=%0d, expected lc_en=%h en=%b pulse=%b err=%b cnt=%0d",
                   e.name, act.lc_en, act.en, act.pulse, act.err, act.cnt,
                   e.exp.lc_en, e.exp.en, e.exp.pulse, e.exp.err, e.exp.cnt);
        end
      end
    end
  end

  initial begin : stim
    int budget;
    // Reset held with On at the input, then On two edges after release.
    step("rst_hold0", 0, 4'hA, 0, 0, 0, 0);
    step("rst_hold1", 0, 4'hA, 0, 0, 0, 0);
    step("rst_arm",   1, 4'hA, 0, 0, 0, 0);
    step("rst_on",    1, 4'hA, 1, 1, 0, 0);
    step("rst_hold",  1, 4'hA, 1, 0, 0, 0);

    // Legal rise through one transient code.
    step("rise_rst",  0, 4'h5, 0, 0, 0, 0);
    step("rise_off",  1, 4'h5, 0, 0, 0, 0);
    step("rise_inv",  1, 4'h3, 0, 0, 0, 1);
    step("rise_arm",  1, 4'hA, 0, 0, 0, 1);
    step("rise_on",   1, 4'hA, 1, 1, 0, 1);
    step("rise_hold", 1, 4'hA, 1, 0, 0, 1);

    // Fail-safe fall on Off, then again on a single invalid code.
    step("fall_off",  1, 4'h5, 0, 0, 0, 1);
    step("fall_arm",  1, 4'hA, 0, 0, 0, 1);
    step("fall_on",   1, 4'hA, 1, 1, 0, 1);
    step("fall_inv",  1, 4'h0, 0, 0, 0, 2);
    step("fall_stay", 1, 4'h5, 0, 0, 0, 2);

    // Arming interrupted by a glitch restarts the filter.
    step("glt_rst",   0, 4'h5, 0, 0, 0, 0);
    step("glt_arm1",  1, 4'hA, 0, 0, 0, 0);
    step("glt_inv",   1, 4'h7, 0, 0, 0, 1);
    step("glt_arm2",  1, 4'hA, 0, 0, 0, 1);
    step("glt_on",    1, 4'hA, 1, 1, 0, 1);
    step("glt_hold",  1, 4'hA, 1, 0, 0, 1);

    // Two consecutive invalid codes from On are fatal; only reset recovers.
    step("fat_rst",   0, 4'h5, 0, 0, 0, 0);
    step("fat_arm",   1, 4'hA, 0, 0, 0, 0);
    step("fat_on",    1, 4'hA, 1, 1, 0, 0);
    step("fat_inv1",  1, 4'h0, 0, 0, 0, 1);
    step("fat_inv2",  1, 4'hF, 0, 0, 1, 2);
    for (int i = 0; i < 10; i++) step("fat_stuck", 1, 4'hA, 0, 0, 1, 2);
    step("fat_clr",   0, 4'hA, 0, 0, 0, 0);
    step("fat_after", 1, 4'h5, 0, 0, 0, 0);

    // Isolated invalid codes never trip the error but the counter saturates.
    step("sat_i1", 1, 4'h0, 0, 0, 0, 1);
    step("sat_o1", 1, 4'h5, 0, 0, 0, 1);
    step("sat_i2", 1, 4'h0, 0, 0, 0, 2);
    step("sat_o2", 1, 4'h5, 0, 0, 0, 2);
    step("sat_i3", 1, 4'h0, 0, 0, 0, 3);
    step("sat_o3", 1, 4'h5, 0, 0, 0, 3);
    step("sat_i4", 1, 4'h0, 0, 0, 0, 3);
    step("sat_o4", 1, 4'h5, 0, 0, 0, 3);
    step("sat_i5", 1, 4'h0, 0, 0, 0, 3);
    step("sat_o5", 1, 4'h5, 0, 0, 0, 3);

    budget = 100;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk_i);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
